// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 width codes, FSM state encoding and access-legality check for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } lsu_state_t;

    // Unsupported width code or an address not aligned to the access size.
    function automatic logic access_err(input logic is_store, input logic [2:0] f3, input logic [1:0] a);
        logic bad_f3;
        logic mis;
        bad_f3 = is_store ? (f3 > F3_W)
                          : !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        mis    = ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a != 2'b00);
        return bad_f3 || mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a little-endian word and sign/zero-extends it.
//   i_word   : raw 32-bit memory word
//   i_addr   : byte offset within the word
//   i_funct3 : RV32 load width code
//   o_value  : extended load result
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_value
);

    logic [7:0]  w_b;
    logic [15:0] w_h;

    always_comb begin
        w_b     = i_addr == 2'd0 ? i_word[7:0]   :
                  i_addr == 2'd1 ? i_word[15:8]  :
                  i_addr == 2'd2 ? i_word[23:16] : i_word[31:24];
        w_h     = i_addr[1] ? i_word[31:16] : i_word[15:0];
        o_value = i_funct3 == F3_B  ? {{24{w_b[7]}}, w_b}  :
                  i_funct3 == F3_H  ? {{16{w_h[15]}}, w_h} :
                  i_funct3 == F3_BU ? {24'd0, w_b}         :
                  i_funct3 == F3_HU ? {16'd0, w_h}         : i_word;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store sequencer over a synchronous single-port data RAM.
//   req_*      : request from execute stage, accepted when req_valid && req_ready
//   mem_*      : word-aligned RAM port; mem_rdata valid the cycle after mem_re
//   resp_valid : one-cycle completion pulse; err qualifies it; resp_data is the load result
// Sub-word stores are done as read-modify-write so the RAM only needs full-word writes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              err
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              w_accept;
    logic              w_req_err;
    logic [31:0]       w_load_val;
    logic [31:0]       w_mask;
    logic [31:0]       w_lane;
    logic [31:0]       w_merged;

    assign w_accept  = req_valid && r_state == S_IDLE;
    assign w_req_err = access_err(req_is_store, req_funct3, req_addr[1:0]);

    load_extend u_load_extend (
        .i_word   (r_rdata),
        .i_addr   (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_value  (w_load_val)
    );

    // Store data replicated across lanes; the mask picks which lanes replace the read word.
    // For SW the mask is all ones, so the (unread) r_rdata never leaks through.
    assign w_mask   = r_funct3 == F3_B ? 32'h0000_00FF << {r_addr[1:0], 3'b000} :
                      r_funct3 == F3_H ? 32'h0000_FFFF << {r_addr[1], 4'b0000}  : 32'hFFFF_FFFF;
    assign w_lane   = r_funct3 == F3_B ? {4{r_wdata[7:0]}}  :
                      r_funct3 == F3_H ? {2{r_wdata[15:0]}} : r_wdata;
    assign w_merged = (r_rdata & ~w_mask) | (w_lane & w_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_store <= req_is_store;
                r_funct3   <= req_funct3;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_err      <= w_req_err;
            end
            if (r_state == S_WAIT) r_rdata <= mem_rdata;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = r_state == S_IDLE;
        mem_re     = r_state == S_RD;
        mem_we     = r_state == S_WR;
        mem_addr   = (r_state == S_RD || r_state == S_WR) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata  = r_state == S_WR ? w_merged : 32'd0;
        resp_valid = r_state == S_DONE;
        err        = r_state == S_DONE && r_err;
        resp_data  = (r_state == S_DONE && !r_err && !r_is_store) ? w_load_val : 32'd0;
        unique case (r_state)
            S_IDLE: if (req_valid) w_next = w_req_err ? S_DONE :
                                            (req_is_store && req_funct3 == F3_W) ? S_WR : S_RD;
            S_RD:   w_next = S_WAIT;
            S_WAIT: w_next = r_is_store ? S_WR : S_DONE;
            S_WR:   w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench with a 4-word synchronous RAM model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        err;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int rv_cnt = 0;
    int excl_cnt = 0;

    logic [31:0] mem [4];
    logic        pl_en = 1'b0;
    logic [1:0]  pl_idx = 2'd0;
    logic [31:0] pl_val = 32'd0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[3:2]];
        if (mem_we) mem[mem_addr[3:2]] <= mem_wdata;
        else if (pl_en) mem[pl_idx] <= pl_val;
        if (mem_we) we_cnt <= we_cnt + 1;
        if (resp_valid) rv_cnt <= rv_cnt + 1;
        if (mem_re && mem_we) excl_cnt <= excl_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [1:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        present(1'b0, f3, a, 32'd0);
        chk({tag, "_re_t1"}, {31'd0, mem_re}, 32'd1);
        chk({tag, "_addr_t1"}, mem_addr, a & ~32'd3);
        chk({tag, "_busy_t1"}, {30'd0, req_ready, mem_we}, 32'd0);
        @(negedge clk);
        chk({tag, "_t2"}, {30'd0, mem_re, resp_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_rv_t3"}, {30'd0, resp_valid, err}, 32'd2);
        chk({tag, "_data_t3"}, resp_data, exp);
    endtask

    task automatic do_rmw(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
        int w0;
        w0 = we_cnt;
        present(1'b1, f3, a, wd);
        chk({tag, "_re_t1"}, {30'd0, mem_re, mem_we}, 32'd2);
        @(negedge clk);
        chk({tag, "_t2"}, {29'd0, mem_re, mem_we, resp_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_we_t3"}, {30'd0, mem_re, mem_we}, 32'd1);
        chk({tag, "_addr_t3"}, mem_addr, a & ~32'd3);
        chk({tag, "_wdata_t3"}, mem_wdata, exp);
        @(negedge clk);
        chk({tag, "_rv_t4"}, {30'd0, resp_valid, err}, 32'd2);
        chk({tag, "_data_t4"}, resp_data, 32'd0);
        chk({tag, "_we_count"}, we_cnt - w0, 32'd1);
    endtask

    task automatic do_err(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a);
        present(st, f3, a, 32'h1234_5678);
        chk({tag, "_rv_err"}, {28'd0, resp_valid, err, mem_re, mem_we}, 32'hC);
        chk({tag, "_data"}, resp_data, 32'd0);
        @(negedge clk);
        chk({tag, "_after"}, {30'd0, req_ready, resp_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] got [$];
        logic        took;
        int          k;
        int          w0;
        int          r0;
        logic        st_v [3];
        logic [31:0] ad_v [3];
        logic [31:0] wd_v [3];
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_strobes", {28'd0, mem_re, mem_we, resp_valid, err}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        preload(2'd0, 32'hFFF4_1234);
        do_load("lh_102", 3'b001, 32'h102, 32'hFFFF_FFF4);
        preload(2'd0, 32'h80FF_0000);
        do_load("lb_103", 3'b000, 32'h103, 32'hFFFF_FF80);
        do_load("lbu_103", 3'b100, 32'h103, 32'h0000_0080);
        preload(2'd0, 32'h0000_FFFF);
        do_load("lhu_100", 3'b101, 32'h100, 32'h0000_FFFF);
        do_load("lh_100", 3'b001, 32'h100, 32'hFFFF_FFFF);
        preload(2'd1, 32'hDEAD_BEEF);
        do_load("lw_104", 3'b010, 32'h104, 32'hDEAD_BEEF);

        preload(2'd0, 32'h1122_3344);
        do_rmw("sb_101", 3'b000, 32'h101, 32'h0000_00AB, 32'h1122_AB44);
        preload(2'd0, 32'h1122_3344);
        do_rmw("sh_102", 3'b001, 32'h102, 32'h0000_BEEF, 32'hBEEF_3344);

        w0 = we_cnt;
        present(1'b1, 3'b010, 32'h108, 32'hCAFE_BABE);
        chk("sw_we_t1", {30'd0, mem_re, mem_we}, 32'd1);
        chk("sw_addr_t1", mem_addr, 32'h108);
        chk("sw_wdata_t1", mem_wdata, 32'hCAFE_BABE);
        @(negedge clk);
        chk("sw_rv_t2", {30'd0, resp_valid, err}, 32'd2);
        chk("sw_data_t2", resp_data, 32'd0);
        chk("sw_we_count", we_cnt - w0, 32'd1);

        do_err("lw_101", 1'b0, 3'b010, 32'h101);
        do_err("lh_103", 1'b0, 3'b001, 32'h103);
        do_err("sw_102", 1'b1, 3'b010, 32'h102);
        do_err("sh_101", 1'b1, 3'b001, 32'h101);
        do_err("ld_f3_011", 1'b0, 3'b011, 32'h100);
        do_err("st_f3_100", 1'b1, 3'b100, 32'h100);

        w0 = we_cnt;
        r0 = rv_cnt;
        present(1'b1, 3'b001, 32'h100, 32'h0000_5555);
        chk("rst_sh_re_t1", {31'd0, mem_re}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_sh_idle", {29'd0, req_ready, mem_we, resp_valid}, 32'd4);
        repeat (5) @(negedge clk);
        chk("rst_sh_no_we", we_cnt - w0, 32'd0);
        chk("rst_sh_no_rv", rv_cnt - r0, 32'd0);

        preload(2'd0, 32'h0BAD_F00D);
        st_v = '{1'b0, 1'b1, 1'b0};
        ad_v = '{32'h100, 32'h108, 32'h108};
        wd_v = '{32'd0, 32'hCAFE_F00D, 32'd0};
        w0 = we_cnt;
        k = 0;
        req_valid = 1'b1; req_is_store = st_v[0]; req_funct3 = 3'b010; req_addr = ad_v[0]; req_wdata = wd_v[0];
        took = req_ready;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (resp_valid) got.push_back(resp_data);
            if (took) begin
                k++;
                if (k < 3) begin
                    req_is_store = st_v[k]; req_addr = ad_v[k]; req_wdata = wd_v[k];
                end else req_valid = 1'b0;
            end
            took = req_valid && req_ready;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", k, 32'd3);
        chk("b2b_resp_count", got.size(), 32'd3);
        chk("b2b_resp0", got.size() > 0 ? got[0] : 32'hXXXX_XXXX, 32'h0BAD_F00D);
        chk("b2b_resp1", got.size() > 1 ? got[1] : 32'hXXXX_XXXX, 32'd0);
        chk("b2b_resp2", got.size() > 2 ? got[2] : 32'hXXXX_XXXX, 32'hCAFE_F00D);
        chk("b2b_we_count", we_cnt - w0, 32'd1);
        chk("re_we_exclusive", excl_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
